// File: rtl/irq_pkg.sv
// irq_pkg: shared sizes and FSM state encoding for the interrupt pending path
package irq_pkg;
  localparam int N_REQ_DEF = 8;
  localparam int ID_W_DEF = 3;
  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_PRESENT = 1'b1
  } irq_state_e;
endpackage

// File: rtl/irq_prio_enc8.sv
// irq_prio_enc8: highest-set-bit priority encoder, sel=0 when nothing is eligible
module irq_prio_enc8 #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] eligible,
  output logic [W-1:0] sel,
  output logic         any
);
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) sel = eligible[i] ? W'(i) : sel;
  end
  assign any = |eligible;
endmodule

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: sticky masked request capture with priority select and valid/ack presentation
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int EDGE_MODE = 1,
  parameter int CNT_W = 8,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic             irq_ack,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_REQ-1:0] pending,
  output logic [CNT_W-1:0] ovf_cnt
);
  logic [N_REQ-1:0] req_q, rise, clr, eligible, pending_n;
  logic [ID_W-1:0] sel, id_n;
  logic any, lost;
  irq_state_e state, state_n;
  irq_prio_enc8 #(.N(N_REQ)) u_enc (.eligible(eligible), .sel(sel), .any(any));
  always_comb begin
    rise = EDGE_MODE != 0 ? req & ~req_q : '0;
    clr = (EDGE_MODE != 0 && state == IRQ_PRESENT && irq_ack) ? N_REQ'(1) << irq_id : '0;
    pending_n = EDGE_MODE != 0 ? (pending & ~clr) | rise : req;
    lost = |(rise & pending & ~clr);
    eligible = pending & mask;
    state_n = state == IRQ_IDLE ? (any ? IRQ_PRESENT : IRQ_IDLE) : (irq_ack ? IRQ_IDLE : IRQ_PRESENT);
    id_n = (state == IRQ_IDLE && any) ? sel : irq_id;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
      pending <= '0;
      ovf_cnt <= '0;
      irq_id <= '0;
      state <= IRQ_IDLE;
    end else begin
      req_q <= req;
      pending <= pending_n;
      irq_id <= id_n;
      state <= state_n;
      if (lost && ovf_cnt != '1) ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end
  assign irq_valid = state == IRQ_PRESENT;
endmodule
